data_mem_ctrl: RTL

//  Initiator for the data register file: takes load/store requests from the core over a

---
 rtl/data_mem_ctrl_pkg.sv | 26 ++
 rtl/data_mem_ctrl_req_fifo.sv | 56 +++++
 rtl/data_mem_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl_pkg
// Brief   : Shared widths and FSM state encoding for the data regfile
//           initiator (data_mem_ctrl) and its request FIFO.
// Revision: 1.0 - initial release
// ============================================================================
package data_mem_ctrl_pkg;

  // Data word width of the regfile.
  localparam int DMC_DATA_WIDTH     = 16;
  // Regfile address width (2**DMC_DATA_MEM_WIDTH words).
  localparam int DMC_DATA_MEM_WIDTH = 4;
  // Request FIFO depth (power of two, at least 2).
  localparam int DMC_QDEPTH         = 2;

  // Controller FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage : data_mem_ctrl_pkg
`default_nettype wire

// File: rtl/data_mem_ctrl_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl_req_fifo
// Brief   : Small synchronous request FIFO. Occupancy is tracked by read and
//           write pointers carrying one extra wrap bit, so full and empty are
//           told apart without a separate counter.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_ctrl_req_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Guarded strobes: a push into a full FIFO or a pop from an empty one is ignored.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_rdata = r_mem[r_rptr[PW-1:0]];

  // Pointer update; reset empties the queue by realigning the pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{PW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Entry storage; contents are only observed while the pointers say non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
  end

endmodule : data_mem_ctrl_req_fifo
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl
// Brief   : Load/store initiator for the data register file. Requests from
//           the core are queued, issued one at a time to the regfile pins and
//           answered in order on a valid/ready response channel.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DMC_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMC_DATA_MEM_WIDTH,
  parameter int QDEPTH     = DMC_QDEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_is_write,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_data_in,
  output logic                  o_mem_mode,
  input  logic [DATA_WIDTH-1:0] i_mem_data_out,
  output logic                  o_busy
);

  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_head_we;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;

  state_t                r_state;
  logic                  r_cmd_we;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data_in;
  logic                  r_mem_mode;
  logic                  r_rsp_valid;
  logic                  r_rsp_is_write;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Accept whenever there is room; the head is only taken while the FSM is idle.
  assign w_push = i_req_valid & ~w_full;
  assign w_pop  = (r_state == ST_IDLE) & ~w_empty;

  assign {w_head_we, w_head_addr, w_head_wdata} = w_head;

  data_mem_ctrl_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({i_req_we, i_req_addr, i_req_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Command sequencer. The regfile pins are loaded on the IDLE->ISSUE edge so
  // the regfile samples them at the end of ISSUE; its read data then appears
  // during WAIT and is captured on the WAIT->RESP edge. Write enable is high
  // for the ISSUE cycle only. Address and data stay put until the next command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cmd_we       <= 1'b0;
      r_mem_address  <= '0;
      r_mem_data_in  <= '0;
      r_mem_mode     <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_is_write <= 1'b0;
      r_rsp_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd_we      <= w_head_we;
            r_mem_address <= w_head_addr;
            r_mem_data_in <= w_head_wdata;
            r_mem_mode    <= w_head_we;
            r_state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_mode <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_rsp_rdata    <= r_cmd_we ? '0 : i_mem_data_out;
          r_rsp_is_write <= r_cmd_we;
          r_rsp_valid    <= 1'b1;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready    = ~w_full;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_is_write = r_rsp_is_write;
  assign o_rsp_rdata    = r_rsp_rdata;
  assign o_mem_address  = r_mem_address;
  assign o_mem_data_in  = r_mem_data_in;
  assign o_mem_mode     = r_mem_mode;
  assign o_busy         = (r_state != ST_IDLE) | ~w_empty;

endmodule : data_mem_ctrl
`default_nettype wire
